gate_result_checker: RTL and testbench



---
 rtl/gate_result_checker.sv | 123 ++++++++++++
 tb/tb_gate_result_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_checker.sv
// Response checker for bitwise-gate blocks: recomputes AND/OR/XOR/NOT results and keeps pass/fail
// statistics. Define CHECKER_HALT_ON_ERR_EN to stop accepting after the first failure.
module gate_result_checker #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [W-1:0]  in_y,
  output logic          res_valid,
  output logic          res_pass,
  output logic [W-1:0]  res_diff,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          first_fail_vld,
  output logic [CW-1:0] first_fail_idx,
  output logic          halted
);

`ifdef CHECKER_HALT_ON_ERR_EN
  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;
`else
  typedef enum logic [0:0] {StIdle, StRun} state_e;
`endif

  state_e        state_q, state_d;
  logic          accept;
  logic          pass;
  logic [W-1:0]  expected;
  logic [W-1:0]  diff;
  logic [CW-1:0] idx_q;

  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  always_comb begin
    expected = '0;
    case (in_op)
      2'b00:   expected = in_a & in_b;
      2'b01:   expected = in_a | in_b;
      2'b10:   expected = in_a ^ in_b;
      default: expected = ~in_a;
    endcase
  end

  assign diff = expected ^ in_y;
  assign pass = (diff == '0);

`ifdef CHECKER_HALT_ON_ERR_EN
  assign in_ready = !clear && (state_q != StHalt);
  assign halted   = (state_q == StHalt);
`else
  assign in_ready = !clear;
  assign halted   = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          state_d = StRun;
`ifdef CHECKER_HALT_ON_ERR_EN
          if (!pass) state_d = StHalt;
`endif
        end
      end
      default: state_d = state_q;
    endcase
    // clear wins over any acceptance-driven transition
    if (clear) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      res_valid      <= 1'b0;
      res_pass       <= 1'b0;
      res_diff       <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if (clear) begin
      // res_pass/res_diff intentionally hold their last value
      idx_q          <= '0;
      res_valid      <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        res_pass <= pass;
        res_diff <= diff;
        idx_q    <= idx_q + CW'(1);
        if (pass) begin
          if (pass_cnt != CntMax) pass_cnt <= pass_cnt + CW'(1);
        end else begin
          if (fail_cnt != CntMax) fail_cnt <= fail_cnt + CW'(1);
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_result_checker.sv
// Randomized self-checking bench for gate_result_checker against a behavioural model; honours
// CHECKER_HALT_ON_ERR_EN when the build defines it.
module tb_gate_result_checker;
  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MAXC = 255;
`ifdef CHECKER_HALT_ON_ERR_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clear, in_valid;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a, in_b, in_y;
  logic          in_ready, res_valid, res_pass, first_fail_vld, halted;
  logic [W-1:0]  res_diff;
  logic [CW-1:0] pass_cnt, fail_cnt, first_fail_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gate_result_checker #(.W(W), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_y           (in_y),
    .res_valid      (res_valid),
    .res_pass       (res_pass),
    .res_diff       (res_diff),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx),
    .halted         (halted)
  );

  // Behavioural model state
  bit           m_ok = 1'b0;
  int           m_idx, m_pass, m_fail, m_ffi;
  bit           m_ffv, m_halt, m_rv, m_rp;
  logic [W-1:0] m_rd;

  function automatic logic [W-1:0] gate_ref(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Advance the model by the edge that is about to happen, using the inputs now applied.
  task automatic model_step();
    logic [W-1:0] e;
    if (rst) begin
      m_ok = 1'b1;
      m_idx = 0; m_pass = 0; m_fail = 0; m_ffi = 0;
      m_ffv = 0; m_halt = 0; m_rv = 0; m_rp = 0; m_rd = '0;
    end else if (clear) begin
      m_idx = 0; m_pass = 0; m_fail = 0; m_ffi = 0;
      m_ffv = 0; m_halt = 0; m_rv = 0;
    end else begin
      m_rv = in_valid && !m_halt;
      if (m_rv) begin
        e    = gate_ref(in_op, in_a, in_b);
        m_rd = e ^ in_y;
        m_rp = (e == in_y);
        if (m_rp) begin
          if (m_pass < MAXC) m_pass++;
        end else begin
          if (m_fail < MAXC) m_fail++;
          if (!m_ffv) begin
            m_ffv = 1'b1;
            m_ffi = m_idx;
          end
          if (HaltEn) m_halt = 1'b1;
        end
        m_idx = (m_idx + 1) % (MAXC + 1);
      end
    end
  endtask

  // Compare process: registered outputs settle well before the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        check("in_ready", in_ready, !clear && !m_halt);
        check("res_valid", res_valid, m_rv);
        check("res_pass", res_pass, m_rp);
        check("res_diff", res_diff, m_rd);
        check("pass_cnt", pass_cnt, m_pass);
        check("fail_cnt", fail_cnt, m_fail);
        check("first_fail_vld", first_fail_vld, m_ffv);
        check("first_fail_idx", first_fail_idx, m_ffi);
        check("halted", halted, m_halt);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] y);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_y = y;
  endtask

  task automatic do_clear();
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  int pulses;
  logic [W-1:0] ra, rb, ry;
  logic [1:0] rop;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_y = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("lit_reset_ready", in_ready, 1);
    check("lit_reset_pass_cnt", pass_cnt, 0);
    check("lit_reset_res_valid", res_valid, 0);

    // AND C & A = 8
    txn(2'b00, 4'hC, 4'hA, 4'h8);
    tick();
    in_valid = 1'b0;
    check("lit_and_valid", res_valid, 1);
    check("lit_and_pass", res_pass, 1);
    check("lit_and_diff", res_diff, 0);
    check("lit_and_pass_cnt", pass_cnt, 1);

    // NOT ~5 = A, y = B -> diff 1
    do_clear();
    txn(2'b11, 4'h5, 4'hF, 4'hB);
    tick();
    in_valid = 1'b0;
    check("lit_not_pass", res_pass, 0);
    check("lit_not_diff", res_diff, 4'h1);
    check("lit_not_fail_cnt", fail_cnt, 1);
    check("lit_not_ffv", first_fail_vld, 1);
    check("lit_not_ffi", first_fail_idx, 0);

    // Three passes, then XOR 3^5=6 vs 7, then a second failure
    do_clear();
    for (int i = 0; i < 3; i++) begin
      txn(2'b00, 4'h1, 4'h1, 4'h1);
      tick();
    end
    txn(2'b10, 4'h3, 4'h5, 4'h7);
    tick();
    check("lit_xor_diff", res_diff, 4'h1);
    check("lit_xor_ffi", first_fail_idx, 3);
    check("lit_xor_halted", halted, HaltEn);
    check("lit_xor_ready", in_ready, !HaltEn);
    txn(2'b00, 4'hF, 4'hF, 4'h0);
    tick();
    in_valid = 1'b0;
    check("lit_second_fail_cnt", fail_cnt, HaltEn ? 1 : 2);
    check("lit_second_ffi", first_fail_idx, 3);
    check("lit_second_pass_cnt", pass_cnt, 3);

    // 300 back-to-back OR passes: saturation and continuous res_valid
    do_clear();
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      txn(2'b01, ra, rb, ra | rb);
      tick();
      if (res_valid) pulses++;
    end
    in_valid = 1'b0;
    check("lit_or_pulses", pulses, 300);
    check("lit_or_sat", pass_cnt, 255);

    // clear coinciding with a valid transaction
    txn(2'b00, 4'h3, 4'h6, 4'h2);
    clear = 1'b1;
    #1;
    check("lit_clr_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    check("lit_clr_pass_cnt", pass_cnt, 0);
    check("lit_clr_res_valid", res_valid, 0);
    check("lit_clr_halted", halted, 0);
    tick();
    in_valid = 1'b0;
    check("lit_after_clr_valid", res_valid, 1);
    check("lit_after_clr_pass_cnt", pass_cnt, 1);

    // rst right after an accept discards nothing visible later and resets all
    txn(2'b10, 4'h9, 4'h3, 4'hA);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("lit_rst_valid", res_valid, 0);
    check("lit_rst_pass_cnt", pass_cnt, 0);
    check("lit_rst_diff", res_diff, 0);
    check("lit_rst_ready", in_ready, 1);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      rop = 2'($urandom); ra = 4'($urandom); rb = 4'($urandom);
      ry  = ($urandom_range(0, 9) < 7) ? gate_ref(rop, ra, rb) : 4'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = rop; in_a = ra; in_b = rb; in_y = ry;
      clear = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
